centroid_update_engine: RTL

//  Streaming k-means centroid update stage. Consumes (point, class id) beats from the

---
 rtl/kmeans_pkg.sv | 25 ++
 rtl/seq_divider.sv | 89 ++++++++
 rtl/centroid_update_engine.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/kmeans_pkg.sv
// Shared k-means definitions.
//   state_e  : centroid update engine FSM states
//   point_t  : point vector as produced by the classifier ([PT_D-1:0][PT_W-1:0])
//   acc_w()  : sum accumulator width for a coordinate width and member counter width
package kmeans_pkg;

  typedef enum logic [2:0] {
    ACCUM,
    LOAD,
    DIV,
    EMIT,
    DONE
  } state_e;

  localparam int PT_D = 2;
  localparam int PT_W = 32;

  typedef logic [PT_D-1:0][PT_W-1:0] point_t;

  // A sum of up to 2**cnt_w-1 values of w bits fits in w+cnt_w bits.
  function automatic int acc_w(input int w, input int cnt_w);
    return w + cnt_w;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   start      : load dividend/divisor (may be asserted in the cycle done is high)
//   dividend   : ACC_W-bit numerator
//   divisor    : ACC_W-bit denominator, never zero
//   busy       : iteration in progress
//   done       : high in the last iteration cycle; quotient is valid in that cycle
//   quotient   : low QUO_W bits of floor(dividend/divisor)
module seq_divider #(
  parameter int ACC_W = 64,
  parameter int QUO_W = ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  input  logic [ACC_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quotient
);

  localparam int STEP_W = $clog2(ACC_W + 1);

  logic              busy_q, busy_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [ACC_W-1:0]  rem_q, rem_d;
  logic [ACC_W-1:0]  quo_q, quo_d;
  logic [ACC_W-1:0]  dvsr_q, dvsr_d;

  logic [ACC_W:0]    rem_shift;
  logic              take;
  logic [ACC_W-1:0]  rem_step;
  logic [ACC_W-1:0]  quo_step;

  always_comb begin
    // Shift the next dividend bit into the partial remainder. The extra MSB is
    // needed because the shifted remainder can reach 2*divisor-1.
    rem_shift = {rem_q, quo_q[ACC_W-1]};
    take      = rem_shift >= {1'b0, dvsr_q};
    // After a subtraction the remainder is below the divisor, so the low bits
    // of the modular difference are exact.
    rem_step  = take ? (rem_shift[ACC_W-1:0] - dvsr_q) : rem_shift[ACC_W-1:0];
    quo_step  = {quo_q[ACC_W-2:0], take};

    busy_d = busy_q;
    step_d = step_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    if (start) begin
      busy_d = 1'b1;
      step_d = STEP_W'(ACC_W);
      rem_d  = '0;
      quo_d  = dividend;
      dvsr_d = divisor;
    end else if (busy_q) begin
      rem_d  = rem_step;
      quo_d  = quo_step;
      step_d = step_q - 1'b1;
      if (step_q == STEP_W'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else begin
      busy_q <= busy_d;
      step_q <= step_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign busy     = busy_q;
  // The final quotient is taken straight from the last step so the caller can
  // chain the next division without an idle cycle.
  assign done     = busy_q && (step_q == STEP_W'(1));
  assign quotient = quo_step[QUO_W-1:0];

endmodule

// File: rtl/centroid_update_engine.sv
// Streaming k-means centroid update: accumulates per-cluster coordinate sums and
// member counts from classified points, then on request emits sum/count for every
// cluster in index order using one shared sequential divider.
//   clk, rst              : clock, synchronous active-high reset
//   pt_valid/pt_ready     : point beat handshake (ready only while accumulating)
//   pt_coord, pt_class    : point coordinates and its cluster id
//   start_update          : level request for an emission pass
//   busy                  : pass in progress
//   cent_valid/cent_ready : centroid handshake
//   cent_idx, cent_coord  : cluster index and floor(sum/count) per dimension
//   cent_empty            : cluster had no members (coordinates are zero)
//   done                  : one-cycle pulse after the last centroid is accepted
//   cnt_ovf               : sticky, a point was dropped on a saturated counter
module centroid_update_engine
  import kmeans_pkg::*;
#(
  parameter int K     = 256,
  parameter int D     = 2,
  parameter int W     = 32,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pt_valid,
  output logic                   pt_ready,
  input  logic [D-1:0][W-1:0]    pt_coord,
  input  logic [$clog2(K)-1:0]   pt_class,
  input  logic                   start_update,
  output logic                   busy,
  output logic                   cent_valid,
  input  logic                   cent_ready,
  output logic [$clog2(K)-1:0]   cent_idx,
  output logic [D-1:0][W-1:0]    cent_coord,
  output logic                   cent_empty,
  output logic                   done,
  output logic                   cnt_ovf
);

  localparam int ACC_W = acc_w(W, CNT_W);
  localparam int CLS_W = $clog2(K);
  localparam int DIM_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                  state_q, state_d;
  logic [CLS_W-1:0]        idx_q, idx_d;
  logic [DIM_W-1:0]        dim_q, dim_d;
  logic [D-1:0][W-1:0]     coord_q, coord_d;
  logic                    empty_q, empty_d;
  logic                    ovf_q, ovf_d;

  // Per-cluster register file with a single write port, shared between
  // accumulation (ACCUM) and clear-on-accept (EMIT).
  logic [D-1:0][ACC_W-1:0] sum_q [K];
  logic [CNT_W-1:0]        cnt_q [K];
  logic                    wr_en;
  logic [CLS_W-1:0]        wr_idx;
  logic [D-1:0][ACC_W-1:0] wr_sum;
  logic [CNT_W-1:0]        wr_cnt;

  logic                    class_ok;
  logic [D-1:0][ACC_W-1:0] sum_inc;

  logic                    div_start, div_busy, div_done;
  logic [DIM_W-1:0]        div_dim;
  logic [ACC_W-1:0]        div_dividend, div_divisor;
  logic [W-1:0]            div_quo;

  // Class ids beyond K-1 only exist when K is not a power of two.
  if (K == (1 << CLS_W)) begin : g_class_pow2
    assign class_ok = 1'b1;
  end else begin : g_class_npow2
    assign class_ok = ({1'b0, pt_class} < (CLS_W + 1)'(K));
  end

  for (genvar gi = 0; gi < D; gi++) begin : g_add
    assign sum_inc[gi] = sum_q[pt_class][gi] + ACC_W'(pt_coord[gi]);
  end

  assign div_dividend = sum_q[idx_q][div_dim];
  assign div_divisor  = ACC_W'(cnt_q[idx_q]);

  seq_divider #(
    .ACC_W (ACC_W),
    .QUO_W (W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dim_d      = dim_q;
    coord_d    = coord_q;
    empty_d    = empty_q;
    ovf_d      = ovf_q;
    wr_en      = 1'b0;
    wr_idx     = idx_q;
    wr_sum     = '0;
    wr_cnt     = '0;
    div_start  = 1'b0;
    div_dim    = '0;
    pt_ready   = 1'b0;
    cent_valid = 1'b0;
    done       = 1'b0;

    case (state_q)
      ACCUM: begin
        pt_ready = 1'b1;
        if (pt_valid && class_ok) begin
          if (cnt_q[pt_class] == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_idx = pt_class;
            wr_sum = sum_inc;
            wr_cnt = cnt_q[pt_class] + CNT_W'(1);
          end
        end
        // A beat in the same cycle is written above before the pass begins.
        if (start_update) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        coord_d = '0;
        dim_d   = '0;
        if (cnt_q[idx_q] == '0) begin
          empty_d = 1'b1;
          state_d = EMIT;
        end else begin
          empty_d   = 1'b0;
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          coord_d[dim_q] = div_quo;
          if (dim_q == DIM_W'(D - 1)) begin
            state_d = EMIT;
          end else begin
            // Chain the next dimension so each one costs exactly ACC_W cycles.
            dim_d     = dim_q + 1'b1;
            div_dim   = dim_q + 1'b1;
            div_start = 1'b1;
          end
        end
      end
      EMIT: begin
        cent_valid = 1'b1;
        if (cent_ready) begin
          wr_en  = 1'b1;
          wr_idx = idx_q;
          if (idx_q == CLS_W'(K - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        idx_d   = '0;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      dim_q   <= '0;
      coord_q <= '0;
      empty_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < K; k++) begin
        sum_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dim_q   <= dim_d;
      coord_q <= coord_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      if (wr_en) begin
        sum_q[wr_idx] <= wr_sum;
        cnt_q[wr_idx] <= wr_cnt;
      end
    end
  end

  assign busy       = (state_q == LOAD) || (state_q == DIV) || (state_q == EMIT) || div_busy;
  assign cent_idx   = idx_q;
  assign cent_coord = coord_q;
  assign cent_empty = empty_q;
  assign cnt_ovf    = ovf_q;

endmodule
